sdram_req_arbiter: RTL and testbench

//  Shares the single sdram_controller user port between the CPU Wishbone path and the DMA Wishbone path.

---
 rtl/sdram_req_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_sdram_req_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_arbiter.sv
// Shares the single SDRAM controller user port between the CPU and DMA Wishbone paths.
// One registered grant per transaction, fixed CPU priority, DMA starvation guard, read watchdog.
module sdram_req_arbiter #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  // CPU Wishbone path
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic [3:0]        cpu_sel_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  // DMA Wishbone path
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  input  logic [3:0]        dma_sel_i,
  input  logic              dma_burst_i,
  output logic              dma_ack_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  // status
  output logic              err_o,
  output logic [1:0]        grant_o,
  // SDRAM controller user port
  output logic [ADDR_W-1:0] ctrl_addr_o,
  output logic              ctrl_rw_o,
  output logic [DATA_W-1:0] ctrl_wdata_o,
  output logic [3:0]        ctrl_mask_o,
  output logic              ctrl_in_valid_o,
  output logic              ctrl_burst_en_o,
  input  logic              ctrl_busy_i,
  input  logic              ctrl_out_valid_i,
  input  logic [DATA_W-1:0] ctrl_rdata_i
);

  localparam int unsigned BEAT_W   = $clog2(BURST_LEN + 1);
  localparam int unsigned WDOG_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DMA  = 2'b10;

  localparam logic [DATA_W-1:0] RDATA_ERR = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMD     = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [1:0]          grant_q,     grant_d;
  logic                rw_q,        rw_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [3:0]          mask_q,      mask_d;
  logic                burst_q,     burst_d;
  logic                in_valid_q,  in_valid_d;
  logic [BEAT_W-1:0]   beats_q,     beats_d;
  logic [WDOG_W-1:0]   wdog_q,      wdog_d;
  logic [STARVE_W-1:0] starve_q,    starve_d;
  logic                cpu_ack_q,   cpu_ack_d;
  logic                dma_ack_q,   dma_ack_d;
  logic                err_q,       err_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

  logic req_any;
  logic dma_win;
  logic beat;
  logic last_beat;
  logic timeout;

  // DMA wins when CPU is idle or DMA has lost too many arbitrations in a row
  assign req_any   = cpu_req_i | dma_req_i;
  assign dma_win   = dma_req_i & (~cpu_req_i | (starve_q >= STARVE_W'(STARVE_MAX)));
  assign beat      = (state_q == S_RD_WAIT) & ctrl_out_valid_i;
  assign last_beat = beat & (beats_q == BEAT_W'(1));
  assign timeout   = (state_q == S_RD_WAIT) & ~ctrl_out_valid_i & (wdog_q == WDOG_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) state_d = S_CMD;
      end
      S_CMD: begin
        if (!ctrl_busy_i) state_d = rw_q ? S_RELEASE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (last_beat || timeout) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values of the latched transaction fields and all registered outputs
  always_comb begin
    grant_d     = grant_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    burst_d     = burst_q;
    in_valid_d  = in_valid_q;
    beats_d     = beats_q;
    wdog_d      = wdog_q;
    starve_d    = starve_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    err_d       = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          grant_d    = dma_win ? GNT_DMA : GNT_CPU;
          rw_d       = dma_win ? dma_we_i : cpu_we_i;
          addr_d     = dma_win ? dma_addr_i : cpu_addr_i;
          wdata_d    = dma_win ? dma_wdata_i : cpu_wdata_i;
          mask_d     = dma_win ? (dma_sel_i & {4{dma_we_i}}) : (cpu_sel_i & {4{cpu_we_i}});
          burst_d    = dma_win & dma_burst_i & ~dma_we_i;
          in_valid_d = 1'b1;
          if (dma_win) begin
            starve_d = '0;
          end else if (dma_req_i && (starve_q < STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end
      end
      S_CMD: begin
        if (!ctrl_busy_i) begin
          in_valid_d = 1'b0;
          if (rw_q) begin
            grant_d   = GNT_NONE;
            cpu_ack_d = (grant_q == GNT_CPU);
            dma_ack_d = (grant_q == GNT_DMA);
          end else begin
            beats_d = burst_q ? BEAT_W'(BURST_LEN) : BEAT_W'(1);
            wdog_d  = '0;
          end
        end
      end
      S_RD_WAIT: begin
        if (beat) begin
          cpu_ack_d = (grant_q == GNT_CPU);
          dma_ack_d = (grant_q == GNT_DMA);
          if (grant_q == GNT_CPU) cpu_rdata_d = ctrl_rdata_i;
          if (grant_q == GNT_DMA) dma_rdata_d = ctrl_rdata_i;
          beats_d = beats_q - BEAT_W'(1);
          wdog_d  = '0;
          if (last_beat) grant_d = GNT_NONE;
        end else if (timeout) begin
          // Error completion: remaining beats are abandoned
          cpu_ack_d = (grant_q == GNT_CPU);
          dma_ack_d = (grant_q == GNT_DMA);
          err_d     = 1'b1;
          if (grant_q == GNT_CPU) cpu_rdata_d = RDATA_ERR;
          if (grant_q == GNT_DMA) dma_rdata_d = RDATA_ERR;
          beats_d   = '0;
          grant_d   = GNT_NONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_RELEASE: begin
        grant_d = GNT_NONE;
      end
      default: begin
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= GNT_NONE;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      burst_q     <= 1'b0;
      in_valid_q  <= 1'b0;
      beats_q     <= '0;
      wdog_q      <= '0;
      starve_q    <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      grant_q     <= grant_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      burst_q     <= burst_d;
      in_valid_q  <= in_valid_d;
      beats_q     <= beats_d;
      wdog_q      <= wdog_d;
      starve_q    <= starve_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign cpu_ack_o       = cpu_ack_q;
  assign cpu_rdata_o     = cpu_rdata_q;
  assign dma_ack_o       = dma_ack_q;
  assign dma_rdata_o     = dma_rdata_q;
  assign err_o           = err_q;
  assign grant_o         = grant_q;
  assign ctrl_addr_o     = addr_q;
  assign ctrl_rw_o       = rw_q;
  assign ctrl_wdata_o    = wdata_q;
  assign ctrl_mask_o     = mask_q;
  assign ctrl_in_valid_o = in_valid_q;
  assign ctrl_burst_en_o = burst_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: writes, fairness, bursts, busy stall, watchdog, reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sdram_req_arbiter;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [3:0]        cpu_sel = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req = 1'b0, dma_we = 1'b0, dma_burst = 1'b0;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [DATA_W-1:0] dma_wdata = '0;
  logic [3:0]        dma_sel = '0;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;
  logic              err;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] ctrl_addr;
  logic              ctrl_rw;
  logic [DATA_W-1:0] ctrl_wdata;
  logic [3:0]        ctrl_mask;
  logic              ctrl_in_valid, ctrl_burst_en;
  logic              ctrl_busy = 1'b0, ctrl_out_valid = 1'b0;
  logic [DATA_W-1:0] ctrl_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdram_req_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(4), .STARVE_MAX(2), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_sel_i(cpu_sel), .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_sel_i(dma_sel), .dma_burst_i(dma_burst), .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata),
    .err_o(err), .grant_o(grant),
    .ctrl_addr_o(ctrl_addr), .ctrl_rw_o(ctrl_rw), .ctrl_wdata_o(ctrl_wdata), .ctrl_mask_o(ctrl_mask),
    .ctrl_in_valid_o(ctrl_in_valid), .ctrl_burst_en_o(ctrl_burst_en),
    .ctrl_busy_i(ctrl_busy), .ctrl_out_valid_i(ctrl_out_valid), .ctrl_rdata_i(ctrl_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    cpu_req = 1'b0; dma_req = 1'b0; ctrl_busy = 1'b0; ctrl_out_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL rst_grant: got %b expected 00", grant); end
    n_checks++; if (ctrl_in_valid !== 1'b0) begin n_errors++; $display("FAIL rst_in_valid: got %b expected 0", ctrl_in_valid); end
    n_checks++; if ({cpu_ack, dma_ack, err} !== 3'b000) begin n_errors++; $display("FAIL rst_acks: got %b expected 000", {cpu_ack, dma_ack, err}); end
    n_checks++; if ({ctrl_addr, ctrl_mask, ctrl_rw, ctrl_burst_en} !== '0) begin n_errors++; $display("FAIL rst_ctrl: got %h/%h/%b/%b expected zeros", ctrl_addr, ctrl_mask, ctrl_rw, ctrl_burst_en); end
    n_checks++; if ({cpu_rdata, dma_rdata, ctrl_wdata} !== '0) begin n_errors++; $display("FAIL rst_data: got %h/%h/%h expected zeros", cpu_rdata, dma_rdata, ctrl_wdata); end
  endtask

  task automatic test_cpu_write();
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000100; cpu_wdata = 32'h12345678; cpu_sel = 4'hF;
    tick();
    n_checks++; if (ctrl_in_valid !== 1'b1) begin n_errors++; $display("FAIL wr_in_valid_c1: got %b expected 1", ctrl_in_valid); end
    n_checks++; if (ctrl_mask !== 4'hF) begin n_errors++; $display("FAIL wr_mask_c1: got %h expected F", ctrl_mask); end
    n_checks++; if (ctrl_rw !== 1'b1) begin n_errors++; $display("FAIL wr_rw_c1: got %b expected 1", ctrl_rw); end
    n_checks++; if (ctrl_addr !== 23'h000100) begin n_errors++; $display("FAIL wr_addr_c1: got %h expected 000100", ctrl_addr); end
    n_checks++; if (ctrl_wdata !== 32'h12345678) begin n_errors++; $display("FAIL wr_wdata_c1: got %h expected 12345678", ctrl_wdata); end
    n_checks++; if (grant !== 2'b01) begin n_errors++; $display("FAIL wr_grant_c1: got %b expected 01", grant); end
    n_checks++; if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL wr_ack_c1: got %b expected 0", cpu_ack); end
    tick();
    n_checks++; if (cpu_ack !== 1'b1) begin n_errors++; $display("FAIL wr_ack_c2: got %b expected 1", cpu_ack); end
    n_checks++; if (grant !== 2'b00) begin n_errors++; $display("FAIL wr_grant_c2: got %b expected 00", grant); end
    n_checks++; if (ctrl_in_valid !== 1'b0) begin n_errors++; $display("FAIL wr_in_valid_c2: got %b expected 0", ctrl_in_valid); end
    n_checks++; if ({dma_ack, err} !== 2'b00) begin n_errors++; $display("FAIL wr_dma_err_c2: got %b expected 00", {dma_ack, err}); end
    cpu_req = 1'b0;
    tick();
    n_checks++; if (cpu_ack !== 1'b0) begin n_errors++; $display("FAIL wr_ack_c3: got %b expected 0", cpu_ack); end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_g [6];
    logic [1:0] last_g;
    int k, n_cpu, n_dma;
    exp_g = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    last_g = 2'b00; k = 0; n_cpu = 0; n_dma = 0;
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000011; cpu_wdata = 32'h11111111; cpu_sel = 4'hF;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 23'h000022; dma_wdata = 32'h22222222; dma_sel = 4'hF;
    dma_burst = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (ctrl_in_valid === 1'b1 && k < 6) begin
        n_checks++; if (grant !== exp_g[k]) begin n_errors++; $display("FAIL fair_grant_%0d: got %b expected %b", k, grant, exp_g[k]); end
        n_checks++; if (ctrl_addr !== ((exp_g[k] == 2'b01) ? 23'h000011 : 23'h000022)) begin n_errors++; $display("FAIL fair_addr_%0d: got %h expected %h", k, ctrl_addr, (exp_g[k] == 2'b01) ? 23'h000011 : 23'h000022); end
        last_g = exp_g[k];
        k++;
      end
      if (cpu_ack === 1'b1) begin
        n_cpu++;
        n_checks++; if (last_g !== 2'b01) begin n_errors++; $display("FAIL fair_cpu_ack_owner: got grant %b expected 01", last_g); end
      end
      if (dma_ack === 1'b1) begin
        n_dma++;
        n_checks++; if (last_g !== 2'b10) begin n_errors++; $display("FAIL fair_dma_ack_owner: got grant %b expected 10", last_g); end
      end
      if (n_cpu + n_dma >= 6) begin
        cpu_req = 1'b0; dma_req = 1'b0;
        break;
      end
      tick();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    n_checks++; if (k !== 6) begin n_errors++; $display("FAIL fair_grant_count: got %0d expected 6", k); end
    n_checks++; if (n_cpu !== 4) begin n_errors++; $display("FAIL fair_cpu_acks: got %0d expected 4", n_cpu); end
    n_checks++; if (n_dma !== 2) begin n_errors++; $display("FAIL fair_dma_acks: got %0d expected 2", n_dma); end
    tick();
    tick();
    n_checks++; if ({ctrl_in_valid, grant} !== 3'b000) begin n_errors++; $display("FAIL fair_idle_after: got %b expected 000", {ctrl_in_valid, grant}); end
  endtask

  task automatic test_dma_burst();
    logic [10:0] vld;
    logic        exp_dack;
    logic [1:0]  exp_g;
    int nb, na;
    vld = 11'b00001001101;
    nb = 0; na = 0;
    apply_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_burst = 1'b1; dma_addr = 23'h7F0000; dma_sel = 4'hF;
    tick();
    n_checks++; if ({ctrl_in_valid, grant, ctrl_burst_en, ctrl_rw} !== 5'b11010) begin n_errors++; $display("FAIL burst_cmd: got %b expected 11010", {ctrl_in_valid, grant, ctrl_burst_en, ctrl_rw}); end
    n_checks++; if ({ctrl_addr, ctrl_mask} !== {23'h7F0000, 4'h0}) begin n_errors++; $display("FAIL burst_fields: got %h/%h expected 7F0000/0", ctrl_addr, ctrl_mask); end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000200; cpu_wdata = 32'h55AA55AA; cpu_sel = 4'hF;
    tick();
    for (int i = 0; i <= 10; i++) begin
      exp_dack = (i > 0) ? vld[i-1] : 1'b0;
      exp_g = (i <= 6) ? 2'b10 : ((i == 9) ? 2'b01 : 2'b00);
      n_checks++; if (dma_ack !== exp_dack) begin n_errors++; $display("FAIL burst_dma_ack_%0d: got %b expected %b", i, dma_ack, exp_dack); end
      if (exp_dack) begin
        n_checks++; if (dma_rdata !== 32'hA0 + 32'(na)) begin n_errors++; $display("FAIL burst_rdata_%0d: got %h expected %h", na, dma_rdata, 32'hA0 + 32'(na)); end
        na++;
      end
      n_checks++; if (grant !== exp_g) begin n_errors++; $display("FAIL burst_grant_%0d: got %b expected %b", i, grant, exp_g); end
      n_checks++; if (cpu_ack !== (i == 10)) begin n_errors++; $display("FAIL burst_cpu_ack_%0d: got %b expected %b", i, cpu_ack, i == 10); end
      n_checks++; if (ctrl_in_valid !== (i == 9)) begin n_errors++; $display("FAIL burst_in_valid_%0d: got %b expected %b", i, ctrl_in_valid, i == 9); end
      ctrl_out_valid = vld[i];
      ctrl_rdata = vld[i] ? 32'hA0 + 32'(nb) : 32'h0;
      if (vld[i]) nb++;
      if (i == 7) dma_req = 1'b0;
      if (i == 10) cpu_req = 1'b0;
      tick();
    end
    n_checks++; if (na !== 4) begin n_errors++; $display("FAIL burst_beat_count: got %0d expected 4", na); end
  endtask

  task automatic test_busy_stall();
    apply_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_burst = 1'b0; dma_addr = 23'h0ABCDE; dma_wdata = 32'hCAFEF00D; dma_sel = 4'h3;
    ctrl_busy = 1'b1;
    tick();
    for (int j = 1; j <= 5; j++) begin
      n_checks++; if ({ctrl_in_valid, grant, ctrl_rw, ctrl_mask} !== 8'b1_10_1_0011) begin n_errors++; $display("FAIL busy_ctrl_%0d: got %b expected 11010011", j, {ctrl_in_valid, grant, ctrl_rw, ctrl_mask}); end
      n_checks++; if ({ctrl_addr, ctrl_wdata} !== {23'h0ABCDE, 32'hCAFEF00D}) begin n_errors++; $display("FAIL busy_fields_%0d: got %h/%h expected 0ABCDE/CAFEF00D", j, ctrl_addr, ctrl_wdata); end
      n_checks++; if (dma_ack !== 1'b0) begin n_errors++; $display("FAIL busy_early_ack_%0d: got %b expected 0", j, dma_ack); end
      tick();
    end
    ctrl_busy = 1'b0;
    n_checks++; if (ctrl_in_valid !== 1'b1) begin n_errors++; $display("FAIL busy_in_valid_c6: got %b expected 1", ctrl_in_valid); end
    tick();
    n_checks++; if ({dma_ack, cpu_ack, ctrl_in_valid, grant} !== 5'b10000) begin n_errors++; $display("FAIL busy_ack_c7: got %b expected 10000", {dma_ack, cpu_ack, ctrl_in_valid, grant}); end
    dma_req = 1'b0;
    tick();
    n_checks++; if (dma_ack !== 1'b0) begin n_errors++; $display("FAIL busy_ack_c8: got %b expected 0", dma_ack); end
  endtask

  task automatic test_timeout();
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000055; cpu_sel = 4'hF;
    tick();
    n_checks++; if ({ctrl_in_valid, ctrl_rw, ctrl_mask} !== 6'b10_0000) begin n_errors++; $display("FAIL to_cmd: got %b expected 100000", {ctrl_in_valid, ctrl_rw, ctrl_mask}); end
    tick();
    for (int k = 1; k <= 16; k++) begin
      n_checks++; if ({cpu_ack, err, grant} !== 4'b0001) begin n_errors++; $display("FAIL to_wait_%0d: got %b expected 0001", k, {cpu_ack, err, grant}); end
      tick();
    end
    n_checks++; if ({cpu_ack, err, dma_ack, grant} !== 5'b11000) begin n_errors++; $display("FAIL to_ack_err: got %b expected 11000", {cpu_ack, err, dma_ack, grant}); end
    n_checks++; if (cpu_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL to_rdata: got %h expected DEADBEEF", cpu_rdata); end
    cpu_req = 1'b0;
    tick();
    n_checks++; if ({cpu_ack, err} !== 2'b00) begin n_errors++; $display("FAIL to_after: got %b expected 00", {cpu_ack, err}); end
    cpu_req = 1'b1; cpu_addr = 23'h000066;
    tick();
    n_checks++; if ({ctrl_in_valid, ctrl_addr} !== {1'b1, 23'h000066}) begin n_errors++; $display("FAIL to_next_cmd: got %b/%h expected 1/000066", ctrl_in_valid, ctrl_addr); end
    tick();
    ctrl_out_valid = 1'b1; ctrl_rdata = 32'h13579BDF;
    tick();
    ctrl_out_valid = 1'b0;
    n_checks++; if ({cpu_ack, err} !== 2'b10) begin n_errors++; $display("FAIL to_next_ack: got %b expected 10", {cpu_ack, err}); end
    n_checks++; if (cpu_rdata !== 32'h13579BDF) begin n_errors++; $display("FAIL to_next_rdata: got %h expected 13579BDF", cpu_rdata); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    apply_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_burst = 1'b1; dma_addr = 23'h7F0010; dma_sel = 4'hF;
    tick();
    tick();
    ctrl_out_valid = 1'b1; ctrl_rdata = 32'hB0;
    tick();
    n_checks++; if ({dma_ack, dma_rdata} !== {1'b1, 32'hB0}) begin n_errors++; $display("FAIL rstmid_beat0: got %b/%h expected 1/000000B0", dma_ack, dma_rdata); end
    ctrl_rdata = 32'hB1; rst = 1'b1; dma_req = 1'b0;
    tick();
    rst = 1'b0; ctrl_out_valid = 1'b1; ctrl_rdata = 32'hEE;
    n_checks++; if ({dma_ack, cpu_ack, err, grant, ctrl_in_valid, ctrl_burst_en, ctrl_rw, ctrl_mask} !== '0) begin n_errors++; $display("FAIL rstmid_flags: got %b expected zeros", {dma_ack, cpu_ack, err, grant, ctrl_in_valid, ctrl_burst_en, ctrl_rw, ctrl_mask}); end
    n_checks++; if ({dma_rdata, ctrl_addr} !== '0) begin n_errors++; $display("FAIL rstmid_data: got %h/%h expected zeros", dma_rdata, ctrl_addr); end
    tick();
    ctrl_out_valid = 1'b0;
    n_checks++; if ({dma_ack, dma_rdata, grant, ctrl_in_valid} !== '0) begin n_errors++; $display("FAIL rstmid_stray: got %b/%h/%b/%b expected zeros", dma_ack, dma_rdata, grant, ctrl_in_valid); end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000100; cpu_wdata = 32'h12345678; cpu_sel = 4'hF;
    tick();
    n_checks++; if ({ctrl_in_valid, ctrl_mask, ctrl_rw, grant} !== 8'b1_1111_1_01) begin n_errors++; $display("FAIL rstmid_wr_c1: got %b expected 11111101", {ctrl_in_valid, ctrl_mask, ctrl_rw, grant}); end
    tick();
    n_checks++; if ({cpu_ack, grant} !== 3'b100) begin n_errors++; $display("FAIL rstmid_wr_c2: got %b expected 100", {cpu_ack, grant}); end
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_starvation();
    test_dma_burst();
    test_busy_stall();
    test_timeout();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
